// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM arbiter between the instruction-fetch client
// and the load/store client.
//
// Multi-byte accesses are serialised onto an 8-bit RAM port. Reads are
// pipelined at one byte per cycle, and the RAM returns each byte one cycle
// after its address. Load/store has strict priority over fetch. Stores stall
// on io_buffer_full. Loads are sign- or zero-extended. An in-flight fetch can
// be flushed.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr/if_flush      fetch request, base address, flush
//   if_valid/if_addr_out/if_data fetch completion pulse, base address, data (LE)
//   ls_req/ls_we/ls_addr         load/store request, store select, base address
//   ls_wdata/ls_len/ls_signed    store data, length (1/2/4), load sign-extend
//   ls_done/ls_rdata             load/store completion pulse, extended load data
//   mem_din/io_buffer_full       RAM read byte, RAM write back-pressure
//   mem_dout/mem_a/mem_wr        RAM write byte, address, write strobe
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDR_W-1:0]        if_addr,
    input  logic                     if_flush,
    output logic                     if_valid,
    output logic [ADDR_W-1:0]        if_addr_out,
    output logic [8*FETCH_BYTES-1:0] if_data,
    input  logic                     ls_req,
    input  logic                     ls_we,
    input  logic [ADDR_W-1:0]        ls_addr,
    input  logic [31:0]              ls_wdata,
    input  logic [2:0]               ls_len,
    input  logic                     ls_signed,
    output logic                     ls_done,
    output logic [31:0]              ls_rdata,
    input  logic [7:0]               mem_din,
    input  logic                     io_buffer_full,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr
);
    localparam int unsigned CntW   = $clog2(FETCH_BYTES + 1);
    localparam int unsigned FetchW = 8 * FETCH_BYTES;

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CntW-1:0]     len_q, len_d;
    logic [CntW-1:0]     issue_q, issue_d;
    logic [CntW-1:0]     recv_q, recv_d;
    logic                is_fetch_q, is_fetch_d;
    logic                signed_q, signed_d;
    logic [FetchW-1:0]   buf_q, buf_d;
    logic                if_valid_q, if_valid_d;
    logic [ADDR_W-1:0]   if_addr_out_q, if_addr_out_d;
    logic [FetchW-1:0]   if_data_q, if_data_d;
    logic                ls_done_q, ls_done_d;
    logic [31:0]         ls_rdata_q, ls_rdata_d;
    logic [CntW-1:0]     ls_len_n;

    // Lengths other than 1 and 2 are treated as a full word.
    always_comb begin
        case (ls_len)
            3'd1:    ls_len_n = CntW'(1);
            3'd2:    ls_len_n = CntW'(2);
            default: ls_len_n = CntW'(4);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        len_d         = len_q;
        issue_d       = issue_q;
        recv_d        = recv_q;
        is_fetch_d    = is_fetch_q;
        signed_d      = signed_q;
        buf_d         = buf_q;
        if_valid_d    = 1'b0;
        if_addr_out_d = if_addr_out_q;
        if_data_d     = if_data_q;
        ls_done_d     = 1'b0;
        ls_rdata_d    = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                issue_d = '0;
                recv_d  = '0;
                // A request is blocked during its own completion cycle so a
                // held level request is not served twice.
                if (ls_req && !ls_done_q) begin
                    base_d     = ls_addr;
                    wdata_d    = ls_wdata;
                    len_d      = ls_len_n;
                    signed_d   = ls_signed;
                    is_fetch_d = 1'b0;
                    state_d    = ls_we ? StWrite : StRead;
                end else if (if_req && !if_flush && !if_valid_q) begin
                    base_d     = if_addr;
                    len_d      = CntW'(FETCH_BYTES);
                    is_fetch_d = 1'b1;
                    state_d    = StRead;
                end
            end

            StWrite: begin
                if (!io_buffer_full) begin
                    if (issue_q + CntW'(1) == len_q) begin
                        state_d   = StIdle;
                        issue_d   = '0;
                        ls_done_d = 1'b1;
                    end else begin
                        issue_d = issue_q + CntW'(1);
                    end
                end
            end

            StRead: begin
                if (is_fetch_q && if_flush) begin
                    state_d = StIdle;
                    issue_d = '0;
                    recv_d  = '0;
                end else begin
                    if (issue_q != len_q) begin
                        issue_d = issue_q + CntW'(1);
                    end
                    // Byte recv_q was addressed last cycle; its data is on mem_din now.
                    if (recv_q != issue_q) begin
                        for (int unsigned b = 0; b < FETCH_BYTES; b++) begin
                            if (recv_q == CntW'(b)) begin
                                buf_d[8*b +: 8] = mem_din;
                            end
                        end
                        if (recv_q + CntW'(1) == len_q) begin
                            state_d = StIdle;
                            issue_d = '0;
                            recv_d  = '0;
                            if (is_fetch_q) begin
                                if_valid_d    = 1'b1;
                                if_data_d     = buf_d;
                                if_addr_out_d = base_q;
                            end else begin
                                ls_done_d = 1'b1;
                                case (len_q)
                                    CntW'(1): ls_rdata_d = {{24{signed_q & buf_d[7]}},
                                                            buf_d[7:0]};
                                    CntW'(2): ls_rdata_d = {{16{signed_q & buf_d[15]}},
                                                            buf_d[15:0]};
                                    default:  ls_rdata_d = buf_d[31:0];
                                endcase
                            end
                        end else begin
                            recv_d = recv_q + CntW'(1);
                        end
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // RAM-side outputs depend only on state and counters (plus RAM back-pressure).
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        unique case (state_q)
            StWrite: begin
                mem_a    = base_q + ADDR_W'(issue_q);
                mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
                mem_wr   = !io_buffer_full;
            end
            StRead: begin
                if (issue_q != len_q) begin
                    mem_a = base_q + ADDR_W'(issue_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            base_q        <= '0;
            wdata_q       <= '0;
            len_q         <= '0;
            issue_q       <= '0;
            recv_q        <= '0;
            is_fetch_q    <= 1'b0;
            signed_q      <= 1'b0;
            buf_q         <= '0;
            if_valid_q    <= 1'b0;
            if_addr_out_q <= '0;
            if_data_q     <= '0;
            ls_done_q     <= 1'b0;
            ls_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            len_q         <= len_d;
            issue_q       <= issue_d;
            recv_q        <= recv_d;
            is_fetch_q    <= is_fetch_d;
            signed_q      <= signed_d;
            buf_q         <= buf_d;
            if_valid_q    <= if_valid_d;
            if_addr_out_q <= if_addr_out_d;
            if_data_q     <= if_data_d;
            ls_done_q     <= ls_done_d;
            ls_rdata_q    <= ls_rdata_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_addr_out = if_addr_out_q;
    assign if_data     = if_data_q;
    assign ls_done     = ls_done_q;
    assign ls_rdata    = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a default instance (32-bit address,
// 4-byte fetch) and a second instance (17-bit address, 8-byte fetch) for
// address wrap and mid-access reset.
module tb_mem_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned FB  = 4;
    localparam int unsigned AW8 = 17;
    localparam int unsigned FB8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Default instance
    logic            rst;
    logic            if_req, if_flush, if_valid;
    logic [AW-1:0]   if_addr, if_addr_out;
    logic [8*FB-1:0] if_data;
    logic            ls_req, ls_we, ls_signed, ls_done;
    logic [AW-1:0]   ls_addr;
    logic [31:0]     ls_wdata, ls_rdata;
    logic [2:0]      ls_len;
    logic [7:0]      mem_din, mem_dout;
    logic            io_buffer_full, mem_wr;
    logic [AW-1:0]   mem_a;

    // Wide-fetch, narrow-address instance
    logic             rst8;
    logic             if_req8, if_flush8, if_valid8;
    logic [AW8-1:0]   if_addr8, if_addr_out8;
    logic [8*FB8-1:0] if_data8;
    logic             ls_req8, ls_we8, ls_signed8, ls_done8;
    logic [AW8-1:0]   ls_addr8;
    logic [31:0]      ls_wdata8, ls_rdata8;
    logic [2:0]       ls_len8;
    logic [7:0]       mem_din8, mem_dout8;
    logic             io_full8, mem_wr8;
    logic [AW8-1:0]   mem_a8;

    mem_arbiter #(.ADDR_W(AW), .FETCH_BYTES(FB)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_addr_out(if_addr_out), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_len(ls_len), .ls_signed(ls_signed), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_arbiter #(.ADDR_W(AW8), .FETCH_BYTES(FB8)) u_dut8 (
        .clk(clk), .rst(rst8),
        .if_req(if_req8), .if_addr(if_addr8), .if_flush(if_flush8),
        .if_valid(if_valid8), .if_addr_out(if_addr_out8), .if_data(if_data8),
        .ls_req(ls_req8), .ls_we(ls_we8), .ls_addr(ls_addr8), .ls_wdata(ls_wdata8),
        .ls_len(ls_len8), .ls_signed(ls_signed8), .ls_done(ls_done8), .ls_rdata(ls_rdata8),
        .mem_din(mem_din8), .io_buffer_full(io_full8),
        .mem_dout(mem_dout8), .mem_a(mem_a8), .mem_wr(mem_wr8)
    );

    // Reference memory: sparse overrides on top of a deterministic fill pattern.
    logic [7:0] mem_model [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ (a[15:8] * 8'd7) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_byte(a);
    endfunction

    // RAM returns the byte one cycle after its address.
    always @(posedge clk) mem_din  <= mem_rd(mem_a);
    always @(posedge clk) mem_din8 <= init_byte(32'(mem_a8));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_fetch(input logic [31:0] addr);
        logic [8*FB-1:0] exp_data;
        int done_cyc;
        for (int b = 0; b < int'(FB); b++) exp_data[8*b +: 8] = mem_rd(addr + 32'(b));
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        @(posedge clk);
        done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            #1;
            if (c == 1) if_req = 1'b0;
            @(negedge clk);
            if (c <= int'(FB)) begin
                n_checks++;
                if (mem_a !== addr + 32'(c - 1) || mem_wr !== 1'b0)
                    $display("FAIL fetch_addr c%0d: mem_a=%h wr=%b want %h wr=0",
                             c, mem_a, mem_wr, addr + 32'(c - 1));
                else n_pass++;
            end
            if (if_valid) done_cyc = c;
            else @(posedge clk);
        end
        n_checks++;
        if (done_cyc != int'(FB) + 2)
            $display("FAIL fetch_latency: valid in cycle %0d want %0d", done_cyc, FB + 2);
        else n_pass++;
        n_checks++;
        if (if_data !== exp_data || if_addr_out !== addr)
            $display("FAIL fetch_data: data=%h addr=%h want %h %h",
                     if_data, if_addr_out, exp_data, addr);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (if_valid !== 1'b0 || if_data !== exp_data)
            $display("FAIL fetch_pulse: valid=%b data=%h want 0 %h", if_valid, if_data, exp_data);
        else n_pass++;
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [2:0] len, input logic sgn);
        int n, done_cyc;
        logic [31:0] raw, exp_v;
        longint v;
        n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        raw = '0;
        for (int b = 0; b < n; b++) raw[8*b +: 8] = mem_rd(addr + 32'(b));
        v = longint'(raw);
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        exp_v = 32'(v);
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr; ls_len = len; ls_signed = sgn;
        ls_wdata = 32'($urandom);
        @(posedge clk);
        done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            #1;
            if (c == 1) begin ls_req = 1'b0; ls_addr = '1; ls_len = 3'd2; end
            @(negedge clk);
            if (c <= n) begin
                n_checks++;
                if (mem_a !== addr + 32'(c - 1))
                    $display("FAIL load_addr c%0d: mem_a=%h want %h", c, mem_a, addr + 32'(c - 1));
                else n_pass++;
            end
            if (ls_done) done_cyc = c;
            else @(posedge clk);
        end
        n_checks++;
        if (done_cyc != n + 2 || ls_rdata !== exp_v)
            $display("FAIL load_result a=%h len=%0d s=%b: done cycle %0d data %h want %0d %h",
                     addr, len, sgn, done_cyc, ls_rdata, n + 2, exp_v);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ls_done !== 1'b0 || ls_rdata !== exp_v)
            $display("FAIL load_pulse: done=%b data=%h want 0 %h", ls_done, ls_rdata, exp_v);
        else n_pass++;
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [2:0] len,
                             input logic [31:0] data, input logic [15:0] stall,
                             output int done_cyc);
        int n, k, exp_done, nw;
        logic [31:0] wa [8];
        logic [7:0]  wd [8];
        n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        // Each non-stalled cycle writes one byte; done follows the last write.
        k = 0;
        exp_done = 1;
        while (k < n) begin
            if (!(exp_done < 16 && stall[exp_done])) k++;
            exp_done++;
        end
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = addr; ls_len = len; ls_wdata = data;
        @(posedge clk);
        done_cyc = 0;
        nw = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            #1;
            if (c == 1) begin ls_req = 1'b0; ls_wdata = ~data; ls_addr = ~addr; end
            io_buffer_full = (c < 16) ? stall[c] : 1'b0;
            @(negedge clk);
            if (mem_wr) begin
                if (nw < 8) begin wa[nw] = mem_a; wd[nw] = mem_dout; end
                nw++;
            end
            if (ls_done) done_cyc = c;
            else @(posedge clk);
        end
        io_buffer_full = 1'b0;
        n_checks++;
        if (nw != n)
            $display("FAIL store_count a=%h: %0d writes want %0d", addr, nw, n);
        else n_pass++;
        for (int b = 0; b < n && b < nw; b++) begin
            n_checks++;
            if (wa[b] !== addr + 32'(b) || wd[b] !== data[8*b +: 8])
                $display("FAIL store_byte%0d: a=%h d=%h want %h %h",
                         b, wa[b], wd[b], addr + 32'(b), data[8*b +: 8]);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc != exp_done)
            $display("FAIL store_latency: done cycle %0d want %0d", done_cyc, exp_done);
        else n_pass++;
        for (int b = 0; b < n; b++) mem_model[addr + 32'(b)] = data[8*b +: 8];
    endtask

    task automatic test_reset();
        rst = 1'b0; rst8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_valid, ls_done, mem_wr} !== 3'b000)
            $display("FAIL reset_pulses: valid/done/wr=%b want 000", {if_valid, ls_done, mem_wr});
        else n_pass++;
        n_checks++;
        if (if_addr_out !== '0 || if_data !== '0 || ls_rdata !== '0)
            $display("FAIL reset_data: addr_out=%h if_data=%h rdata=%h want 0",
                     if_addr_out, if_data, ls_rdata);
        else n_pass++;
        n_checks++;
        if (mem_a !== '0 || mem_dout !== '0)
            $display("FAIL reset_mem: mem_a=%h dout=%h want 0", mem_a, mem_dout);
        else n_pass++;
        rst = 1'b1; rst8 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_a !== '0 || mem_wr !== 1'b0 || if_valid8 !== 1'b0)
            $display("FAIL idle_after_reset: mem_a=%h wr=%b valid8=%b", mem_a, mem_wr, if_valid8);
        else n_pass++;
    endtask

    task automatic test_fetch_basic();
        mem_model[32'h100] = 8'h13; mem_model[32'h101] = 8'h05;
        mem_model[32'h102] = 8'h00; mem_model[32'h103] = 8'h00;
        run_fetch(32'h100);
        n_checks++;
        if (if_data !== 32'h0000_0513 || if_addr_out !== 32'h100)
            $display("FAIL fetch_known: data=%h addr=%h want 00000513 100", if_data, if_addr_out);
        else n_pass++;
    endtask

    task automatic test_load_extend();
        mem_model[32'h20] = 8'h80;
        mem_model[32'h40] = 8'h01; mem_model[32'h41] = 8'h80;
        run_load(32'h20, 3'd1, 1'b1);
        n_checks++;
        if (ls_rdata !== 32'hFFFF_FF80) $display("FAIL sbyte: got %h want FFFFFF80", ls_rdata);
        else n_pass++;
        run_load(32'h20, 3'd1, 1'b0);
        n_checks++;
        if (ls_rdata !== 32'h0000_0080) $display("FAIL ubyte: got %h want 00000080", ls_rdata);
        else n_pass++;
        run_load(32'h40, 3'd2, 1'b1);
        n_checks++;
        if (ls_rdata !== 32'hFFFF_8001) $display("FAIL shalf: got %h want FFFF8001", ls_rdata);
        else n_pass++;
    endtask

    task automatic test_store_stall();
        int d;
        run_store(32'h30000, 3'd4, 32'hDEAD_BEEF, 16'h0004, d);
        n_checks++;
        if (d != 6) $display("FAIL store_stall_done: cycle %0d want 6", d);
        else n_pass++;
        run_load(32'h30000, 3'd4, 1'b0);
        n_checks++;
        if (ls_rdata !== 32'hDEAD_BEEF) $display("FAIL store_readback: got %h want DEADBEEF", ls_rdata);
        else n_pass++;
    endtask

    task automatic test_priority();
        int done_at, valid_at, n_done;
        logic [31:0] exp_f;
        for (int b = 0; b < 4; b++) exp_f[8*b +: 8] = mem_rd(32'h100 + 32'(b));
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_len = 3'd1; ls_signed = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk);
        done_at = 0; valid_at = 0; n_done = 0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (c == 4) if_req = 1'b0;
            if (c == 5) ls_req = 1'b0;
            @(negedge clk);
            if (ls_done) begin n_done++; if (done_at == 0) done_at = c; end
            if (if_valid && valid_at == 0) valid_at = c;
            if (c == 1) begin
                n_checks++;
                if (mem_a !== 32'h20) $display("FAIL prio_load_first: mem_a=%h want 20", mem_a);
                else n_pass++;
            end
            if (c == 4) begin
                n_checks++;
                if (mem_a !== 32'h100) $display("FAIL prio_fetch_start: mem_a=%h want 100", mem_a);
                else n_pass++;
            end
            @(posedge clk);
        end
        n_checks++;
        if (done_at != 3 || n_done != 1)
            $display("FAIL prio_load_once: done cycle %0d count %0d want 3 1", done_at, n_done);
        else n_pass++;
        n_checks++;
        if (valid_at != 9 || if_data !== exp_f)
            $display("FAIL prio_fetch: valid cycle %0d data %h want 9 %h", valid_at, if_data, exp_f);
        else n_pass++;
    endtask

    task automatic test_flush();
        int n_valid;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h200;
        @(posedge clk);
        n_valid = 0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (c == 3) begin if_flush = 1'b1; if_req = 1'b0; end
            if (c == 4) if_flush = 1'b0;
            @(negedge clk);
            if (if_valid) n_valid++;
            if (c == 2) begin
                n_checks++;
                if (mem_a !== 32'h201) $display("FAIL flush_pre: mem_a=%h want 201", mem_a);
                else n_pass++;
            end
            if (c == 4) begin
                n_checks++;
                if (mem_a !== 32'h0) $display("FAIL flush_idle: mem_a=%h want 0", mem_a);
                else n_pass++;
            end
            @(posedge clk);
        end
        n_checks++;
        if (n_valid != 0) $display("FAIL flush_no_valid: %0d pulses want 0", n_valid);
        else n_pass++;
        run_load(32'h4010, 3'd4, 1'b0);
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 30; it++) begin
            logic [31:0] a;
            a = 32'h4000 + 32'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: run_load(a, 3'($urandom_range(0, 7)), 1'($urandom));
                1: run_store(a, 3'($urandom_range(0, 7)), 32'($urandom),
                             16'($urandom) & 16'($urandom), d);
                default: run_fetch(a);
            endcase
        end
    endtask

    task automatic test_wrap_reset8();
        int valid_at, n_valid;
        logic [63:0] exp8;
        logic [AW8-1:0] ea;
        for (int b = 0; b < int'(FB8); b++) begin
            ea = 17'h1FFFC + 17'(b);
            exp8[8*b +: 8] = init_byte(32'(ea));
        end
        @(negedge clk);
        if_req8 = 1'b1; if_addr8 = 17'h1FFFC;
        @(posedge clk);
        valid_at = 0;
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (c == 1) if_req8 = 1'b0;
            @(negedge clk);
            if (c <= int'(FB8)) begin
                ea = 17'h1FFFC + 17'(c - 1);
                n_checks++;
                if (mem_a8 !== ea) $display("FAIL wrap_addr c%0d: mem_a=%h want %h", c, mem_a8, ea);
                else n_pass++;
            end
            if (if_valid8 && valid_at == 0) valid_at = c;
            @(posedge clk);
        end
        n_checks++;
        if (valid_at != 10 || if_data8 !== exp8 || if_addr_out8 !== 17'h1FFFC)
            $display("FAIL wrap_fetch: valid cycle %0d data %h addr %h want 10 %h 1fffc",
                     valid_at, if_data8, if_addr_out8, exp8);
        else n_pass++;
        // Reset in the middle of a second fetch.
        @(negedge clk);
        if_req8 = 1'b1; if_addr8 = 17'h00010;
        @(posedge clk);
        #1 if_req8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b0;
        #1;
        n_checks++;
        if ({if_valid8, ls_done8, mem_wr8} !== 3'b000 || mem_a8 !== '0 || mem_dout8 !== '0 ||
            if_data8 !== '0 || if_addr_out8 !== '0 || ls_rdata8 !== '0)
            $display("FAIL reset8_outs: a=%h d=%h data=%h addr=%h want all 0",
                     mem_a8, mem_dout8, if_data8, if_addr_out8);
        else n_pass++;
        @(negedge clk);
        rst8 = 1'b1;
        n_valid = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (if_valid8) n_valid++;
        end
        n_checks++;
        if (n_valid != 0 || mem_a8 !== '0)
            $display("FAIL reset8_abandon: %0d valid pulses, mem_a=%h want 0 0", n_valid, mem_a8);
        else n_pass++;
    endtask

    initial begin
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_len = 3'd4;
        ls_signed = 1'b0; io_buffer_full = 1'b0;
        if_req8 = 1'b0; if_flush8 = 1'b0; if_addr8 = '0;
        ls_req8 = 1'b0; ls_we8 = 1'b0; ls_addr8 = '0; ls_wdata8 = '0; ls_len8 = 3'd4;
        ls_signed8 = 1'b0; io_full8 = 1'b0;
        rst = 1'b0; rst8 = 1'b0;
        test_reset();
        test_fetch_basic();
        test_load_extend();
        test_store_stall();
        test_priority();
        test_flush();
        test_random();
        test_wrap_reset8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
